// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - staged reset sequencer and lock-loss monitor for the CPU clock domain
module clk_rst_seq #(
    parameter int LOCK_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int SOFT_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       rst_mem_n,
    output logic       rst_cpu_n,
    output logic       rst_io_n,
    output logic       ready,
    output logic [3:0] loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_MEM   = 3'd2,
        REL_CPU   = 3'd3,
        RUN       = 3'd4,
        SOFT      = 3'd5
    } state_t;

    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(STAGE_GAP - 1);
    localparam logic [7:0] SOFT_LAST  = 8'(SOFT_CYCLES - 1);

    logic [1:0] sync_q, sync_d;
    logic       locked_s;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] loss_q, loss_d;
    logic       rst_mem_q, rst_mem_d;
    logic       rst_cpu_q, rst_cpu_d;
    logic       rst_io_q, rst_io_d;
    logic       ready_q, ready_d;
    logic       lost;

    assign sync_d   = {sync_q[0], locked};
    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        lost    = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) state_d = STABLE;
            end
            STABLE: begin
                // Losing lock here is not counted: nothing has been released yet.
                if (!locked_s)               state_d = WAIT_LOCK;
                else if (cnt_q == LOCK_LAST) state_d = REL_MEM;
                else                         cnt_d = cnt_q + 8'd1;
            end
            REL_MEM: begin
                if (!locked_s)              lost = 1'b1;
                else if (cnt_q == GAP_LAST) state_d = REL_CPU;
                else                        cnt_d = cnt_q + 8'd1;
            end
            REL_CPU: begin
                if (!locked_s)              lost = 1'b1;
                else if (cnt_q == GAP_LAST) state_d = RUN;
                else                        cnt_d = cnt_q + 8'd1;
            end
            RUN: begin
                if (!locked_s)         lost = 1'b1;
                else if (soft_rst_req) state_d = SOFT;
            end
            SOFT: begin
                if (!locked_s)               lost = 1'b1;
                else if (cnt_q == SOFT_LAST) state_d = REL_CPU;
                else                         cnt_d = cnt_q + 8'd1;
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (lost) begin
            state_d = WAIT_LOCK;
            if (loss_q != 4'hF) loss_d = loss_q + 4'd1;
        end
        if (state_d != state_q) cnt_d = 8'd0;

        // Outputs are decoded from the next state so they register on the transition edge.
        rst_mem_d = 1'b0;
        rst_cpu_d = 1'b0;
        rst_io_d  = 1'b0;
        ready_d   = 1'b0;
        case (state_d)
            REL_MEM: rst_mem_d = 1'b1;
            REL_CPU: begin
                rst_mem_d = 1'b1;
                rst_cpu_d = 1'b1;
            end
            RUN: begin
                rst_mem_d = 1'b1;
                rst_cpu_d = 1'b1;
                rst_io_d  = 1'b1;
                ready_d   = 1'b1;
            end
            SOFT:    rst_mem_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            state_q   <= WAIT_LOCK;
            cnt_q     <= 8'd0;
            loss_q    <= 4'd0;
            rst_mem_q <= 1'b0;
            rst_cpu_q <= 1'b0;
            rst_io_q  <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            rst_mem_q <= rst_mem_d;
            rst_cpu_q <= rst_cpu_d;
            rst_io_q  <= rst_io_d;
            ready_q   <= ready_d;
        end
    end

    assign rst_mem_n = rst_mem_q;
    assign rst_cpu_n = rst_cpu_q;
    assign rst_io_n  = rst_io_q;
    assign ready     = ready_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - directed self-checking bench for clk_rst_seq
module tb_clk_rst_seq;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       soft_rst_req;
    logic       rst_mem_n;
    logic       rst_cpu_n;
    logic       rst_io_n;
    logic       ready;
    logic [3:0] loss_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    clk_rst_seq dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .locked       (locked),
        .soft_rst_req (soft_rst_req),
        .rst_mem_n    (rst_mem_n),
        .rst_cpu_n    (rst_cpu_n),
        .rst_io_n     (rst_io_n),
        .ready        (ready),
        .loss_cnt     (loss_cnt),
        .state        (state)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic m, input logic c, input logic i,
                           input logic r, input logic [2:0] s);
        chk({tag, ".mem"},   8'(rst_mem_n), 8'(m));
        chk({tag, ".cpu"},   8'(rst_cpu_n), 8'(c));
        chk({tag, ".io"},    8'(rst_io_n),  8'(i));
        chk({tag, ".ready"}, 8'(ready),     8'(r));
        chk({tag, ".state"}, 8'(state),     8'(s));
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        locked       = 1'b0;
        soft_rst_req = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0, 0, 3'd0);
        chk("reset.loss", 8'(loss_cnt), 8'd0);

        // Unstable lock: 10 cycles high, 3 low, then high for good.
        @(negedge clk_in) rst_n = 1'b1;
        edges(3);
        chk("idle.state", 8'(state), 8'd0);
        @(negedge clk_in) locked = 1'b1;
        edges(10);
        chk_out("unstable.stable", 0, 0, 0, 0, 3'd1);
        @(negedge clk_in) locked = 1'b0;
        edges(3);
        chk_out("unstable.back", 0, 0, 0, 0, 3'd0);
        chk("unstable.loss", 8'(loss_cnt), 8'd0);
        @(negedge clk_in) locked = 1'b1;
        edges(2);
        chk("pwr.e1", 8'(state), 8'd0);
        edges(1);
        chk("pwr.e2", 8'(state), 8'd1);
        edges(15);
        chk_out("pwr.e17", 0, 0, 0, 0, 3'd1);
        edges(1);
        chk_out("pwr.e18", 1, 0, 0, 0, 3'd2);
        edges(7);
        chk_out("pwr.e25", 1, 0, 0, 0, 3'd2);
        edges(1);
        chk_out("pwr.e26", 1, 1, 0, 0, 3'd3);
        edges(7);
        chk_out("pwr.e33", 1, 1, 0, 0, 3'd3);
        edges(1);
        chk_out("pwr.e34", 1, 1, 1, 1, 3'd4);
        chk("pwr.loss", 8'(loss_cnt), 8'd0);

        // One-cycle soft reset request.
        @(negedge clk_in) soft_rst_req = 1'b1;
        edges(1);
        soft_rst_req = 1'b0;
        chk_out("soft.e0", 1, 0, 0, 0, 3'd5);
        edges(3);
        chk_out("soft.e3", 1, 0, 0, 0, 3'd5);
        edges(1);
        chk_out("soft.e4", 1, 1, 0, 0, 3'd3);
        edges(7);
        chk_out("soft.e11", 1, 1, 0, 0, 3'd3);
        edges(1);
        chk_out("soft.e12", 1, 1, 1, 1, 3'd4);

        // Request held through SOFT and REL_CPU retriggers only once RUN is reached.
        @(negedge clk_in) soft_rst_req = 1'b1;
        edges(1);
        chk("hold.e0", 8'(state), 8'd5);
        edges(4);
        chk("hold.e4", 8'(state), 8'd3);
        edges(7);
        chk("hold.e11", 8'(state), 8'd3);
        edges(1);
        chk_out("hold.e12", 1, 1, 1, 1, 3'd4);
        edges(1);
        chk_out("hold.e13", 1, 0, 0, 0, 3'd5);
        soft_rst_req = 1'b0;
        edges(4);
        chk("hold.e17", 8'(state), 8'd3);
        edges(8);
        chk_out("hold.e25", 1, 1, 1, 1, 3'd4);

        // Lock loss in RUN.
        @(negedge clk_in) locked = 1'b0;
        edges(2);
        chk_out("loss.e1", 1, 1, 1, 1, 3'd4);
        edges(1);
        chk_out("loss.e2", 0, 0, 0, 0, 3'd0);
        chk("loss.cnt1", 8'(loss_cnt), 8'd1);
        edges(2);
        chk("loss.wait", 8'(state), 8'd0);
        @(negedge clk_in) locked = 1'b1;
        edges(35);
        chk_out("loss.rerun", 1, 1, 1, 1, 3'd4);

        // Soft request and synchronized lock loss reach the FSM on the same edge.
        @(negedge clk_in) locked = 1'b0;
        edges(2);
        chk("simul.e1", 8'(state), 8'd4);
        @(negedge clk_in) soft_rst_req = 1'b1;
        edges(1);
        chk_out("simul.e2", 0, 0, 0, 0, 3'd0);
        chk("simul.loss", 8'(loss_cnt), 8'd2);
        @(negedge clk_in) soft_rst_req = 1'b0;
        edges(2);
        chk("simul.after", 8'(state), 8'd0);

        // Loss in REL_MEM, then async reset mid REL_CPU.
        @(negedge clk_in) locked = 1'b1;
        edges(19);
        chk_out("relmem", 1, 0, 0, 0, 3'd2);
        @(negedge clk_in) locked = 1'b0;
        edges(3);
        chk("relmem.loss", 8'(loss_cnt), 8'd3);
        @(negedge clk_in) locked = 1'b1;
        edges(27);
        chk_out("arst.pre", 1, 1, 0, 0, 3'd3);
        chk("arst.pre.loss", 8'(loss_cnt), 8'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_out("arst", 0, 0, 0, 0, 3'd0);
        chk("arst.loss", 8'(loss_cnt), 8'd0);
        @(negedge clk_in) rst_n = 1'b1;

        // Saturating loss counter over 17 losses.
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk_in) locked = 1'b1;
            edges(19);
            @(negedge clk_in) locked = 1'b0;
            edges(3);
            if (i == 15) chk("sat.15", 8'(loss_cnt), 8'd15);
        end
        chk("sat.17", 8'(loss_cnt), 8'd15);
        chk_out("sat.end", 0, 0, 0, 0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
